axi_beat_sequencer: RTL and testbench

//  Accepts one AXI AW/AR-style burst command (addr/len/size/burst) at a time and emits one

---
 rtl/axi_beat_sequencer_if.sv | 59 +++++
 rtl/axi_beat_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_axi_beat_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_beat_sequencer_if.sv
// ----------------------------------------------------------------------------
// axi_beat_sequencer_if
//   Bundles the command channel, the beat descriptor channel and the reject
//   pulse of axi_beat_sequencer.
//
//   Modports
//     slave  : the sequencer (consumes commands, produces beats and err)
//     master : the environment (issues commands, consumes beats)
//
//   Handshake rule for both channels: a transfer happens on a rising clock
//   edge where valid and ready are both high. Once valid is raised it stays
//   high, with every payload field unchanged, until that transfer. Ready may
//   change freely and never depends combinationally on valid.
// ----------------------------------------------------------------------------
interface axi_beat_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LW     = (STRB_W > 1) ? $clog2(STRB_W) : 1;

  // command channel
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [7:0]            cmd_len_i;
  logic [2:0]            cmd_size_i;
  logic [1:0]            cmd_burst_i;

  // beat descriptor channel
  logic                  beat_valid_o;
  logic                  beat_ready_i;
  logic [ADDR_WIDTH-1:0] beat_addr_o;
  logic [LW-1:0]         beat_lsb_o;
  logic [LW-1:0]         beat_msb_o;
  logic [7:0]            beat_idx_o;
  logic                  beat_last_o;

  // command rejected (one-cycle pulse)
  logic                  err_o;

  modport slave (
    input  cmd_valid_i, cmd_addr_i, cmd_len_i, cmd_size_i, cmd_burst_i,
    output cmd_ready_o,
    output beat_valid_o, beat_addr_o, beat_lsb_o, beat_msb_o, beat_idx_o,
    output beat_last_o,
    input  beat_ready_i,
    output err_o
  );

  modport master (
    output cmd_valid_i, cmd_addr_i, cmd_len_i, cmd_size_i, cmd_burst_i,
    input  cmd_ready_o,
    input  beat_valid_o, beat_addr_o, beat_lsb_o, beat_msb_o, beat_idx_o,
    input  beat_last_o,
    output beat_ready_i,
    input  err_o
  );
endinterface

// File: rtl/axi_beat_sequencer.sv
// ----------------------------------------------------------------------------
// axi_beat_sequencer
//   Takes one AXI AW/AR-style burst command at a time and emits one registered
//   beat descriptor per beat (address, active byte-lane range, index, last).
//   Commands the bridge cannot execute are rejected with a one-cycle err pulse
//   and produce no beats.
//
//   Ports
//     clk_i        rising-edge clock
//     arst_ni      asynchronous active-low reset
//     bus          axi_beat_sequencer_if.slave (command, beat, err)
//     dbg_state_o  current FSM state (0 IDLE, 1 BURST, 2 ERR)
//
//   Optional feature
//     AXI_SEQ_4K_CHECK_EN : when defined, INCR bursts that cross a 4 KB
//                           boundary are rejected. Undefined (default): they
//                           run straight across the boundary.
// ----------------------------------------------------------------------------
module axi_beat_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  axi_beat_sequencer_if.slave       bus,
  output logic [1:0]                dbg_state_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LW     = (STRB_W > 1) ? $clog2(STRB_W) : 1;
  localparam int MAX_SZ = $clog2(STRB_W);

  localparam logic [1:0] B_FIXED = 2'b00;
  localparam logic [1:0] B_INCR  = 2'b01;
  localparam logic [1:0] B_WRAP  = 2'b10;
  localparam logic [1:0] B_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t state_q;

  // registered outputs
  logic                  beat_valid_q;
  logic [ADDR_WIDTH-1:0] beat_addr_q;
  logic [LW-1:0]         beat_lsb_q;
  logic [LW-1:0]         beat_msb_q;
  logic [7:0]            beat_idx_q;
  logic                  beat_last_q;
  logic                  err_q;

  // per-burst context
  logic [7:0]            len_q;
  logic [1:0]            burst_q;
  logic [ADDR_WIDTH-1:0] nb_q;       // bytes per beat
  logic [LW-1:0]         nb_m1_q;    // bytes per beat - 1, in lane units
  logic [ADDR_WIDTH-1:0] total_q;    // bytes in the whole burst
  logic [ADDR_WIDTH-1:0] wb_q;       // wrap boundary base
  logic [ADDR_WIDTH-1:0] run_q;      // aligned address of the current beat

  // --------------------------------------------------------------------------
  // Command decode
  // --------------------------------------------------------------------------
  logic [7:0]            cmd_nb;
  logic [15:0]           cmd_len_p1;
  logic [15:0]           cmd_total;
  logic [ADDR_WIDTH-1:0] cmd_nb_a;
  logic [ADDR_WIDTH-1:0] cmd_total_a;
  logic [ADDR_WIDTH-1:0] cmd_aligned;
  logic [ADDR_WIDTH-1:0] cmd_wb;
  logic [LW-1:0]         cmd_nb_m1;
  logic                  wrap_len_ok;
  logic                  cmd_illegal;
  logic                  cross_4k;

  // len+1 shifted by size equals nb*(len+1) without a multiplier.
  assign cmd_nb      = 8'd1 << bus.cmd_size_i;
  assign cmd_len_p1  = {8'd0, bus.cmd_len_i} + 16'd1;
  assign cmd_total   = cmd_len_p1 << bus.cmd_size_i;
  assign cmd_nb_a    = ADDR_WIDTH'(cmd_nb);
  assign cmd_total_a = ADDR_WIDTH'(cmd_total);
  assign cmd_aligned = bus.cmd_addr_i & ~(cmd_nb_a - 1'b1);
  // Only meaningful for legal WRAP, where the total is a power of two.
  assign cmd_wb      = bus.cmd_addr_i & ~(cmd_total_a - 1'b1);
  assign cmd_nb_m1   = LW'(cmd_nb - 8'd1);

  assign wrap_len_ok = (bus.cmd_len_i == 8'd1) || (bus.cmd_len_i == 8'd3) ||
                       (bus.cmd_len_i == 8'd7) || (bus.cmd_len_i == 8'd15);

`ifdef AXI_SEQ_4K_CHECK_EN
  assign cross_4k = (bus.cmd_burst_i == B_INCR) &&
                    (({5'd0, cmd_aligned[11:0]} + {1'b0, cmd_total}) > 17'd4096);
`else
  assign cross_4k = 1'b0;
`endif

  assign cmd_illegal = (bus.cmd_burst_i == B_RSVD) ||
                       (int'(bus.cmd_size_i) > MAX_SZ) ||
                       ((bus.cmd_burst_i == B_WRAP) && !wrap_len_ok) ||
                       ((bus.cmd_burst_i == B_WRAP) &&
                        ((bus.cmd_addr_i & (cmd_nb_a - 1'b1)) != '0)) ||
                       cross_4k;

  // --------------------------------------------------------------------------
  // Next-beat address: one add per beat plus a wrap compare. The compare is
  // done on the offset from the wrap base so it stays correct when the wrap
  // window sits at the very top of the address space.
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] run_inc;
  logic [ADDR_WIDTH-1:0] run_off;
  logic [ADDR_WIDTH-1:0] run_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [LW-1:0]         lsb_nxt;

  assign run_inc  = run_q + nb_q;
  assign run_off  = run_inc - wb_q;
  assign run_nxt  = ((burst_q == B_WRAP) && (run_off >= total_q)) ? (run_inc - total_q)
                                                                  : run_inc;
  // FIXED bursts keep repeating the original (possibly unaligned) address.
  assign addr_nxt = (burst_q == B_FIXED) ? beat_addr_q : run_nxt;
  assign lsb_nxt  = addr_nxt[LW-1:0];

  // --------------------------------------------------------------------------
  // FSM and beat registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q      <= S_IDLE;
      beat_valid_q <= 1'b0;
      beat_addr_q  <= '0;
      beat_lsb_q   <= '0;
      beat_msb_q   <= '0;
      beat_idx_q   <= '0;
      beat_last_q  <= 1'b0;
      err_q        <= 1'b0;
      len_q        <= '0;
      burst_q      <= '0;
      nb_q         <= '0;
      nb_m1_q      <= '0;
      total_q      <= '0;
      wb_q         <= '0;
      run_q        <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid_i) begin
            if (cmd_illegal) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q      <= S_BURST;
              beat_valid_q <= 1'b1;
              // Beat 0 keeps the unaligned start address; its upper lane
              // still comes from the aligned address.
              beat_addr_q  <= bus.cmd_addr_i;
              beat_lsb_q   <= bus.cmd_addr_i[LW-1:0];
              beat_msb_q   <= cmd_aligned[LW-1:0] + cmd_nb_m1;
              beat_idx_q   <= 8'd0;
              beat_last_q  <= (bus.cmd_len_i == 8'd0);
              len_q        <= bus.cmd_len_i;
              burst_q      <= bus.cmd_burst_i;
              nb_q         <= cmd_nb_a;
              nb_m1_q      <= cmd_nb_m1;
              total_q      <= cmd_total_a;
              wb_q         <= cmd_wb;
              run_q        <= cmd_aligned;
            end
          end
        end
        S_BURST: begin
          if (beat_valid_q && bus.beat_ready_i) begin
            if (beat_last_q) begin
              state_q      <= S_IDLE;
              beat_valid_q <= 1'b0;
            end else begin
              beat_addr_q <= addr_nxt;
              beat_lsb_q  <= lsb_nxt;
              beat_msb_q  <= lsb_nxt + nb_m1_q;
              beat_idx_q  <= beat_idx_q + 8'd1;
              beat_last_q <= ((beat_idx_q + 8'd1) == len_q);
              run_q       <= run_nxt;
            end
          end
        end
        S_ERR: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o  = (state_q == S_IDLE);
  assign bus.beat_valid_o = beat_valid_q;
  assign bus.beat_addr_o  = beat_addr_q;
  assign bus.beat_lsb_o   = beat_lsb_q;
  assign bus.beat_msb_o   = beat_msb_q;
  assign bus.beat_idx_o   = beat_idx_q;
  assign bus.beat_last_o  = beat_last_q;
  assign bus.err_o        = err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_axi_beat_sequencer.sv
// ----------------------------------------------------------------------------
// tb_axi_beat_sequencer
//   Directed bench for axi_beat_sequencer with DATA_WIDTH=32 (4 byte lanes).
//   Inputs change 1 time unit after the rising edge; the beat monitor samples
//   on the falling edge.
// ----------------------------------------------------------------------------
module tb_axi_beat_sequencer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 2;
  localparam int DESC_W = AW + LW + LW + 8 + 1;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk_i = 1'b0;
  logic arst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  axi_beat_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  logic [1:0] dbg_state;

  axi_beat_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // --------------------------------------------------------------------------
  // Check bookkeeping
  // --------------------------------------------------------------------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
  endtask

  function automatic logic [DESC_W-1:0] pack(input logic [AW-1:0] a, input logic [LW-1:0] l,
                                              input logic [LW-1:0] m, input logic [7:0] i,
                                              input logic la);
    return {a, l, m, i, la};
  endfunction

  // --------------------------------------------------------------------------
  // Scoreboard: expected beats, consumed on each observed handshake
  // --------------------------------------------------------------------------
  logic [DESC_W-1:0] exp_q[$];
  logic [DESC_W-1:0] cur_desc;
  logic [DESC_W-1:0] held_desc;
  logic [DESC_W-1:0] exp_d;
  logic              stall_q = 1'b0;

  assign cur_desc = pack(bus.beat_addr_o, bus.beat_lsb_o, bus.beat_msb_o,
                         bus.beat_idx_o, bus.beat_last_o);

  always @(negedge clk_i) begin
    if (arst_ni) begin
      if (stall_q && bus.beat_valid_o) check("hold_stable", cur_desc, held_desc);
      if (bus.beat_valid_o && bus.beat_ready_i) begin
        check("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_d = exp_q.pop_front();
          check("beat", cur_desc, exp_d);
        end
      end
      stall_q   = bus.beat_valid_o && !bus.beat_ready_i;
      held_desc = cur_desc;
    end else begin
      stall_q = 1'b0;
    end
  end

  // beat_ready toggler (mode 1) driven away from the edge
  bit toggle_mode = 1'b0;
  always @(posedge clk_i) begin
    #2;
    if (toggle_mode) bus.beat_ready_i = ~bus.beat_ready_i;
  end

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  // Returns 1 time unit after the accept edge.
  task automatic issue(input logic [AW-1:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    @(posedge clk_i); #1;
    check("cmd_ready_before_issue", bus.cmd_ready_o, 1'b1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_addr_i  = addr;
    bus.cmd_len_i   = len;
    bus.cmd_size_i  = size;
    bus.cmd_burst_i = burst;
    @(posedge clk_i); #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (bus.cmd_ready_o && !bus.beat_valid_o) break;
      @(posedge clk_i); #1;
    end
    check({tag, "_idle"}, bus.cmd_ready_o, 1'b1);
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, bus.beat_valid_o, 1'b0);
    check({tag, "_desc"}, cur_desc, '0);
    check({tag, "_err"}, bus.err_o, 1'b0);
    check({tag, "_ready"}, bus.cmd_ready_o, 1'b1);
    check({tag, "_state"}, dbg_state, 2'd0);
  endtask

  task automatic illegal_cmd(input string tag, input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    issue(addr, len, size, burst);
    check({tag, "_err_n1"}, bus.err_o, 1'b1);
    check({tag, "_valid_n1"}, bus.beat_valid_o, 1'b0);
    check({tag, "_ready_n1"}, bus.cmd_ready_o, 1'b0);
    @(posedge clk_i); #1;
    check({tag, "_err_n2"}, bus.err_o, 1'b0);
    check({tag, "_valid_n2"}, bus.beat_valid_o, 1'b0);
    check({tag, "_ready_n2"}, bus.cmd_ready_o, 1'b1);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_addr_i   = '0;
    bus.cmd_len_i    = '0;
    bus.cmd_size_i   = '0;
    bus.cmd_burst_i  = '0;
    bus.beat_ready_i = 1'b1;

    // reset state
    #1;
    check_zero_outputs("reset");
    @(posedge clk_i); @(posedge clk_i); #1;
    arst_ni = 1'b1;

    // T1: INCR unaligned start, full throughput
    exp_q.push_back(pack(32'h1002, 2'd2, 2'd3, 8'd0, 1'b0));
    exp_q.push_back(pack(32'h1004, 2'd0, 2'd3, 8'd1, 1'b0));
    exp_q.push_back(pack(32'h1008, 2'd0, 2'd3, 8'd2, 1'b0));
    exp_q.push_back(pack(32'h100C, 2'd0, 2'd3, 8'd3, 1'b1));
    issue(32'h1002, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      check("t1_valid_run", bus.beat_valid_o, 1'b1);
      check("t1_ready_low", bus.cmd_ready_o, 1'b0);
      @(posedge clk_i); #1;
    end
    check("t1_valid_after", bus.beat_valid_o, 1'b0);
    check("t1_ready_after", bus.cmd_ready_o, 1'b1);
    wait_idle("t1");

    // T2: WRAP, 16-byte window based at 0x30
    exp_q.push_back(pack(32'h34, 2'd0, 2'd3, 8'd0, 1'b0));
    exp_q.push_back(pack(32'h38, 2'd0, 2'd3, 8'd1, 1'b0));
    exp_q.push_back(pack(32'h3C, 2'd0, 2'd3, 8'd2, 1'b0));
    exp_q.push_back(pack(32'h30, 2'd0, 2'd3, 8'd3, 1'b1));
    issue(32'h34, 8'd3, 3'd2, 2'b10);
    wait_idle("t2");

    // T3: FIXED byte burst with beat_ready toggling
    exp_q.push_back(pack(32'h21, 2'd1, 2'd1, 8'd0, 1'b0));
    exp_q.push_back(pack(32'h21, 2'd1, 2'd1, 8'd1, 1'b0));
    exp_q.push_back(pack(32'h21, 2'd1, 2'd1, 8'd2, 1'b1));
    bus.beat_ready_i = 1'b1;
    toggle_mode = 1'b1;
    issue(32'h21, 8'd2, 3'd0, 2'b00);
    wait_idle("t3");
    toggle_mode = 1'b0;
    bus.beat_ready_i = 1'b1;

    // T4: illegal commands
    illegal_cmd("t4_wrap_len2", 32'h40, 8'd2, 3'd2, 2'b10);
    illegal_cmd("t4_burst_rsvd", 32'h40, 8'd1, 3'd2, 2'b11);
    illegal_cmd("t4_size_too_big", 32'h40, 8'd1, 3'd3, 2'b01);
    illegal_cmd("t4_wrap_unaligned", 32'h42, 8'd3, 3'd2, 2'b10);
    wait_idle("t4");

    // T5: INCR across the 4 KB boundary
`ifdef AXI_SEQ_4K_CHECK_EN
    illegal_cmd("t5_4k", 32'hFF8, 8'd3, 3'd2, 2'b01);
`else
    exp_q.push_back(pack(32'hFF8,  2'd0, 2'd3, 8'd0, 1'b0));
    exp_q.push_back(pack(32'hFFC,  2'd0, 2'd3, 8'd1, 1'b0));
    exp_q.push_back(pack(32'h1000, 2'd0, 2'd3, 8'd2, 1'b0));
    exp_q.push_back(pack(32'h1004, 2'd0, 2'd3, 8'd3, 1'b1));
    issue(32'hFF8, 8'd3, 3'd2, 2'b01);
`endif
    wait_idle("t5");

    // T6: reset in the middle of an 8-beat INCR burst
    exp_q.push_back(pack(32'h200, 2'd0, 2'd3, 8'd0, 1'b0));
    exp_q.push_back(pack(32'h204, 2'd0, 2'd3, 8'd1, 1'b0));
    exp_q.push_back(pack(32'h208, 2'd0, 2'd3, 8'd2, 1'b0));
    issue(32'h200, 8'd7, 3'd2, 2'b01);
    @(posedge clk_i); @(posedge clk_i); @(posedge clk_i); #1;
    check("t6_idx_before_reset", bus.beat_idx_o, 8'd3);
    arst_ni = 1'b0;
    #1;
    check_zero_outputs("t6_reset");
    check("t6_drain", exp_q.size(), 0);
    @(posedge clk_i); #1;
    arst_ni = 1'b1;
    exp_q.push_back(pack(32'h40, 2'd0, 2'd3, 8'd0, 1'b1));
    issue(32'h40, 8'd0, 3'd2, 2'b01);
    check("t6_restart_idx", bus.beat_idx_o, 8'd0);
    check("t6_restart_last", bus.beat_last_o, 1'b1);
    wait_idle("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
